// File: rtl/cnn_layer_ctrl_pkg.sv
// State encodings and shared defaults for the CNN layer sequencer.
// No logic; imported by the sequencer and its ReLU output stage.
package cnn_layer_ctrl_pkg;

  localparam int DATA_LEN_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ZPAD = 3'd1,
    ST_IM2C = 3'd2,
    ST_DOTP = 3'd3,
    ST_BIAS = 3'd4,
    ST_ACTV = 3'd5,
    ST_FINI = 3'd6,
    ST_ERR  = 3'd7
  } layer_state_t;

  function automatic logic is_stage(input layer_state_t s);
    return (s == ST_ZPAD) || (s == ST_IM2C) || (s == ST_DOTP) || (s == ST_BIAS);
  endfunction

endpackage

// File: rtl/cnn_layer_relu_vec.sv
// Element-wise optional ReLU over N signed DATA_LEN fields; combinational, zero latency.
// No flow control: output follows input, pass-through when en is low.
module relu_vec
  import cnn_layer_ctrl_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int N        = 1
) (
  input  logic                  en,
  input  logic [N*DATA_LEN-1:0] d,
  output logic [N*DATA_LEN-1:0] q
);

  for (genvar i = 0; i < N; i++) begin : g_elem
    logic [DATA_LEN-1:0] x;
    assign x = d[i*DATA_LEN +: DATA_LEN];
    // Negative elements clamp to zero; everything else passes unchanged.
    assign q[i*DATA_LEN +: DATA_LEN] = (en && x[DATA_LEN-1]) ? '0 : x;
  end

endmodule

// File: rtl/cnn_layer_ctrl.sv
// Layer sequencer: go/done handshake per stage (zpad, im2c, dotp, bias), then ReLU into q; ACTV adds 1 cycle.
// Result held with valid (or err on stage timeout) until ack or a fresh start; start/ack ignored while busy.
module cnn_layer_ctrl
  import cnn_layer_ctrl_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int OUT_CH   = 32,
  parameter int PIX      = 12,
  parameter int LAYER_W  = 3,
  parameter int TIMEOUT  = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [LAYER_W-1:0]            layer,
  input  logic                          pad_en,
  input  logic                          relu_en,
  input  logic                          ack,
  output logic                          zpad_go,
  output logic                          im2c_go,
  output logic                          dotp_go,
  output logic                          bias_go,
  input  logic                          zpad_done,
  input  logic                          im2c_done,
  input  logic                          dotp_done,
  input  logic                          bias_done,
  output logic [LAYER_W-1:0]            layer_o,
  input  logic [OUT_CH*PIX*DATA_LEN-1:0] bias_d,
  output logic                          busy,
  output logic                          valid,
  output logic                          err,
  output logic [OUT_CH*PIX*DATA_LEN-1:0] q
);

  localparam int VEC_W = OUT_CH * PIX * DATA_LEN;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  layer_state_t     state, state_nxt, first_stage;
  logic [CNT_W-1:0] tmo_cnt;
  logic             relu_cfg;
  logic             in_stage, first_cyc, cur_done, done_ok, tmo_hit, launch;
  logic [VEC_W-1:0] relu_q;

  assign busy  = !((state == ST_IDLE) || (state == ST_FINI) || (state == ST_ERR));
  assign valid = (state == ST_FINI);
  assign err   = (state == ST_ERR);

  // The go pulse marks the first cycle of a stage; a done seen alongside it is ignored.
  assign first_cyc = zpad_go | im2c_go | dotp_go | bias_go;
  assign in_stage  = is_stage(state);
  assign done_ok   = in_stage && cur_done && !first_cyc;
  assign tmo_hit   = (TIMEOUT != 0) && in_stage &&
                     ((32'(tmo_cnt) + 32'd1) == 32'(TIMEOUT));
  assign launch    = start && !busy;

  always_comb begin
    cur_done = 1'b0;
    case (state)
      ST_ZPAD: cur_done = zpad_done;
      ST_IM2C: cur_done = im2c_done;
      ST_DOTP: cur_done = dotp_done;
      ST_BIAS: cur_done = bias_done;
      default: cur_done = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    first_stage = pad_en ? ST_ZPAD : ST_IM2C;
    case (state)
      ST_IDLE: if (start) state_nxt = first_stage;
      ST_ZPAD: if (done_ok) state_nxt = ST_IM2C; else if (tmo_hit) state_nxt = ST_ERR;
      ST_IM2C: if (done_ok) state_nxt = ST_DOTP; else if (tmo_hit) state_nxt = ST_ERR;
      ST_DOTP: if (done_ok) state_nxt = ST_BIAS; else if (tmo_hit) state_nxt = ST_ERR;
      ST_BIAS: if (done_ok) state_nxt = ST_ACTV; else if (tmo_hit) state_nxt = ST_ERR;
      ST_ACTV: state_nxt = ST_FINI;
      // start outranks ack so a restart never detours through IDLE.
      ST_FINI, ST_ERR: begin
        if (start)    state_nxt = first_stage;
        else if (ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  relu_vec #(
    .DATA_LEN (DATA_LEN),
    .N        (OUT_CH * PIX)
  ) u_relu (
    .en (relu_cfg),
    .d  (bias_d),
    .q  (relu_q)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= ST_IDLE;
      tmo_cnt  <= '0;
      zpad_go  <= 1'b0;
      im2c_go  <= 1'b0;
      dotp_go  <= 1'b0;
      bias_go  <= 1'b0;
      relu_cfg <= 1'b0;
      layer_o  <= '0;
      q        <= '0;
    end else begin
      state   <= state_nxt;
      zpad_go <= (state_nxt == ST_ZPAD) && (state != ST_ZPAD);
      im2c_go <= (state_nxt == ST_IM2C) && (state != ST_IM2C);
      dotp_go <= (state_nxt == ST_DOTP) && (state != ST_DOTP);
      bias_go <= (state_nxt == ST_BIAS) && (state != ST_BIAS);

      if (state_nxt != state) tmo_cnt <= '0;
      else if (in_stage)      tmo_cnt <= tmo_cnt + CNT_W'(1);

      if (launch) begin
        layer_o  <= layer;
        relu_cfg <= relu_en;
      end

      if (state == ST_ACTV) q <= relu_q;
    end
  end

endmodule

// File: tb/tb_cnn_layer_ctrl.sv
// Randomized bench for cnn_layer_ctrl: per-run stage schedule computed arithmetically, checked every cycle.
module tb_cnn_layer_ctrl;

  localparam int DL  = 16;
  localparam int OC  = 4;
  localparam int PX  = 2;
  localparam int LW  = 3;
  localparam int TMO = 8;
  localparam int NE  = OC * PX;
  localparam int W   = NE * DL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, ack, pad_en, relu_en;
  logic [LW-1:0] layer, layer_o;
  logic [3:0]    done_v, go_v;
  logic          zpad_go, im2c_go, dotp_go, bias_go;
  logic [W-1:0]  bias_d, q;
  logic          busy, valid, err;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_q;
  bit           exp_err;

  assign go_v = {bias_go, dotp_go, im2c_go, zpad_go};

  always #5 clk = ~clk;

  cnn_layer_ctrl #(
    .DATA_LEN (DL), .OUT_CH (OC), .PIX (PX), .LAYER_W (LW), .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .layer     (layer),
    .pad_en    (pad_en),
    .relu_en   (relu_en),
    .ack       (ack),
    .zpad_go   (zpad_go),
    .im2c_go   (im2c_go),
    .dotp_go   (dotp_go),
    .bias_go   (bias_go),
    .zpad_done (done_v[0]),
    .im2c_done (done_v[1]),
    .dotp_done (done_v[2]),
    .bias_done (done_v[3]),
    .layer_o   (layer_o),
    .bias_d    (bias_d),
    .busy      (busy),
    .valid     (valid),
    .err       (err),
    .q         (q)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] relu_model(input logic [W-1:0] b, input bit en);
    logic [W-1:0] r;
    int v;
    for (int i = 0; i < NE; i++) begin
      v = int'($signed(b[i*DL +: DL]));
      if (en && v < 0) v = 0;
      r[i*DL +: DL] = v[DL-1:0];
    end
    return r;
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_go"}, W'(go_v), '0);
    check_eq({tag, "_busy"}, W'(busy), '0);
    check_eq({tag, "_valid"}, W'(valid), '0);
    check_eq({tag, "_err"}, W'(err), '0);
  endtask

  // Caller is in a cycle where the DUT is IDLE, FINI or ERR; start is raised in this cycle (cycle 0).
  task automatic do_run(input bit pad, input bit relu, input logic [LW-1:0] lay,
                        input int d0, input int d1, input int d2, input int d3,
                        input bit early_im2c, input bit fix_bias, input logic [W-1:0] fbias);
    int dly[4];
    int st[4];
    int cc, err_at, actv, term, cur;
    logic [W-1:0] q_old, q_new, qe;
    dly = '{d0, d1, d2, d3};
    st  = '{-1, -1, -1, -1};
    cc = 1;
    err_at = -1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0 && !pad) continue;
      st[k] = cc;
      if (dly[k] >= TMO) begin
        err_at = cc + TMO;
        break;
      end
      cc += dly[k] + 1;
    end
    actv  = (err_at < 0) ? cc : -1;
    term  = (err_at < 0) ? cc + 1 : err_at;
    q_old = exp_q;
    q_new = exp_q;

    start   = 1'b1;
    ack     = 1'($urandom_range(0, 1));
    pad_en  = pad;
    relu_en = relu;
    layer   = lay;
    done_v  = '0;
    bias_d  = fix_bias ? fbias : rand_vec();
    step();
    for (int c = 1; c <= term; c++) begin
      cur = -1;
      for (int k = 0; k < 4; k++)
        if (st[k] >= 0 && c >= st[k] && c < st[k] + dly[k] + 1) cur = k;
      for (int k = 0; k < 4; k++)
        check_eq($sformatf("go%0d@%0d", k, c), W'(go_v[k]), W'(st[k] == c));
      check_eq($sformatf("busy@%0d", c), W'(busy), W'(c < term));
      check_eq($sformatf("valid@%0d", c), W'(valid), W'(c == term && err_at < 0));
      check_eq($sformatf("err@%0d", c), W'(err), W'(c == term && err_at >= 0));
      check_eq($sformatf("layer_o@%0d", c), W'(layer_o), W'(lay));
      qe = (c == term && err_at < 0) ? q_new : q_old;
      check_eq($sformatf("q@%0d", c), q, qe);
      if (c == term) break;

      bias_d = fix_bias ? fbias : rand_vec();
      if (c == actv) q_new = relu_model(bias_d, relu);
      done_v = '0;
      for (int k = 0; k < 4; k++) begin
        if (st[k] >= 0 && dly[k] < TMO && c == st[k] + dly[k]) done_v[k] = 1'b1;
        if (k == 1 && early_im2c && c == st[k]) done_v[k] = 1'b1;
        if (k != cur && $urandom_range(0, 3) == 0) done_v[k] = 1'b1;
      end
      // Config and handshake noise while busy must not disturb the run.
      start   = ($urandom_range(0, 3) == 0);
      ack     = ($urandom_range(0, 3) == 0);
      pad_en  = 1'($urandom_range(0, 1));
      relu_en = 1'($urandom_range(0, 1));
      layer   = LW'($urandom);
      step();
    end
    start   = 1'b0;
    ack     = 1'b0;
    done_v  = '0;
    exp_err = (err_at >= 0);
    exp_q   = (err_at < 0) ? q_new : q_old;
  endtask

  task automatic hold_and_leave(input int h, input bit use_ack);
    for (int i = 0; i < h; i++) begin
      bias_d = rand_vec();
      step();
      check_eq("hold_go", W'(go_v), '0);
      check_eq("hold_busy", W'(busy), '0);
      check_eq("hold_valid", W'(valid), W'(!exp_err));
      check_eq("hold_err", W'(err), W'(exp_err));
      check_eq("hold_q", q, exp_q);
    end
    if (use_ack) begin
      ack = 1'b1;
      step();
      ack = 1'b0;
      check_quiet("ack_idle");
      check_eq("ack_q", q, exp_q);
      step();
      check_quiet("idle_stays");
    end
  endtask

  initial begin
    logic [W-1:0] fb;
    logic [47:0]  low3;
    rst_n = 1'b1; start = 1'b0; ack = 1'b0; pad_en = 1'b0; relu_en = 1'b0;
    layer = '0; done_v = '0; bias_d = '0;
    exp_q = '0; exp_err = 1'b0;
    repeat (2) step();
    check_quiet("reset");
    check_eq("reset_q", q, '0);
    check_eq("reset_layer", W'(layer_o), '0);
    rst_n = 1'b0;
    step();
    check_quiet("post_reset");

    // Nominal: pad on, relu off, every done one cycle after its go.
    fb = rand_vec();
    fb[15:0] = 16'hFF00;
    do_run(1'b1, 1'b0, 3'd2, 1, 1, 1, 1, 1'b0, 1'b1, fb);
    check_eq("nominal_elem0", W'(q[15:0]), W'(16'hFF00));
    hold_and_leave(2, 1'b1);

    // ReLU on, no padding.
    fb = rand_vec();
    fb[47:0] = {16'h7FFF, 16'h0000, 16'h8000};
    do_run(1'b0, 1'b1, 3'd1, 1, 1, 1, 1, 1'b0, 1'b1, fb);
    low3 = q[47:0];
    check_eq("relu_low3", W'(low3), W'({16'h7FFF, 16'h0000, 16'h0000}));
    hold_and_leave(1, 1'b1);

    // Early im2c done plus random strays, then restart from FINI with layer 5.
    do_run(1'b1, 1'b0, 3'd4, 2, 3, 2, 1, 1'b1, 1'b0, '0);
    hold_and_leave(1, 1'b0);
    do_run(1'b1, 1'b1, 3'd5, 1, 1, 1, 1, 1'b0, 1'b0, '0);
    hold_and_leave(0, 1'b1);

    // dotp never finishes.
    do_run(1'b1, 1'b0, 3'd6, 1, 1, 1000, 1, 1'b0, 1'b0, '0);
    hold_and_leave(3, 1'b1);

    // Reset during DOTP.
    start = 1'b1; pad_en = 1'b0; relu_en = 1'b0; layer = 3'd3;
    step();
    start = 1'b0;
    step();
    done_v[1] = 1'b1;
    step();
    done_v = '0;
    check_eq("pre_reset_dotp_go", W'(dotp_go), W'(1'b1));
    step();
    rst_n = 1'b1;
    #1;
    check_quiet("async_reset");
    check_eq("async_reset_q", q, '0);
    check_eq("async_reset_layer", W'(layer_o), '0);
    exp_q = '0;
    exp_err = 1'b0;
    step();
    rst_n = 1'b0;
    repeat (2) begin
      step();
      check_quiet("release");
    end
    fb = rand_vec();
    fb[15:0] = 16'hFF00;
    do_run(1'b1, 1'b0, 3'd2, 1, 1, 1, 1, 1'b0, 1'b1, fb);
    hold_and_leave(1, 1'b1);

    // Random runs; roughly half restart straight from FINI/ERR.
    for (int r = 0; r < 40; r++) begin
      do_run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), LW'($urandom),
             $urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 9),
             $urandom_range(1, 9), 1'($urandom_range(0, 1)), 1'b0, '0);
      hold_and_leave($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_layer_ctrl.md
# cnn_layer_ctrl

Parametrised sequencer and output stage for one convolution layer. It steps the stage engines through their work: zero padding (optional), im2col, dot product, bias. It then applies an optional ReLU and holds the layer result until the consumer acknowledges it. Compared with the fixed-size layer wrapper it adds:
- configurable tensor size;
- a start/ack handshake;
- per-stage done handshakes with timeout/error reporting;
- per-run mode bits.

## Interface
Parameters:
- DATA_LEN, 16, bits per element; two's complement.
- OUT_CH, 32, output channels.
- PIX, 12, output pixels per channel.
- LAYER_W, 3, width of layer select.
- TIMEOUT, 4096, maximum cycles waiting for a stage done; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-high (name kept for codebase consistency).
- start  in  1  begin a run; honoured only in IDLE, FINI or ERR.
- layer  in  LAYER_W  layer select; latched at start.
- pad_en  in  1  run the zero-padding stage; latched at start.
- relu_en  in  1  apply ReLU at output; latched at start.
- ack  in  1  consumer has taken q; honoured in FINI and ERR.
- zpad_go, im2c_go, dotp_go, bias_go  out  1 each  one-cycle stage start pulse.
- zpad_done, im2c_done, dotp_done, bias_done  in  1 each  stage finished.
- layer_o  out  LAYER_W  latched layer select, fed to dot/bias engines.
- bias_d  in  OUT_CH*PIX*DATA_LEN  bias-stage result.
- busy  out  1  high in every state except IDLE, FINI, ERR.
- valid  out  1  high in FINI.
- err  out  1  high in ERR.
- q  out  OUT_CH*PIX*DATA_LEN  registered layer result.

## Operation
- States: IDLE, ZPAD, IM2C, DOTP, BIAS, ACTV, FINI, ERR.
- Transitions:
  - IDLE + start goes to ZPAD if pad_en, else IM2C.
  - Each stage state advances on its own done: ZPAD→IM2C→DOTP→BIAS→ACTV.
  - ACTV→FINI unconditionally.
- Stage handshake:
  - On entry to a stage state, the matching *_go pulses high for exactly the first cycle in that state.
  - The matching done is sampled only from the second cycle onward. A done coinciding with go is ignored.
  - Done inputs of non-current stages are ignored at all times.
- Timeout:
  - A counter clears on stage entry and increments each cycle in a stage state.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with no done, go to ERR. Done in that same cycle wins.
- ACTV: q is loaded from bias_d. When relu_en is set, each element is max(0, x) on its signed DATA_LEN field; otherwise the element passes unchanged. No width change, no saturation.
- FINI:
  - valid is held and q is stable.
  - ack alone goes to IDLE.
  - start (with or without ack) relatches the config and restarts directly at the first stage.
- ERR:
  - err is held.
  - ack goes to IDLE.
  - start restarts as from FINI.
  - q retains its last value.
- start, ack and config changes while busy are ignored; the latched config is stable for the whole run.

## Timing
- Reset values:
  - state IDLE;
  - q = 0, layer_o = 0;
  - all *_go, busy, valid, err = 0;
  - timeout counter = 0.
- Reset mid-run aborts immediately. No go pulse is emitted on release.
- Minimum run with pad_en=1, each done arriving one cycle after its go, start at cycle 0:
  - ZPAD cycles 1–2, IM2C 3–4, DOTP 5–6, BIAS 7–8;
  - ACTV cycle 9;
  - valid first high cycle 10.
- With pad_en=0, valid is first high at cycle 8.
- Restart from FINI via start: the first go appears in the next cycle; valid drops in that same cycle.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package/include: state encodings (3-bit, extending the existing calc-state defines) and the default DATA_LEN.
- One natural sub-module: relu_vec, a parameterised element-wise ReLU over OUT_CH*PIX fields (generate loop). It is instantiated once in ACTV.

## Test plan
- Nominal, pad_en=1, relu_en=0, done 1 cycle after each go; bias_d element0 = 16'hFF00:
  - go pulses at cycles 1, 3, 5, 7;
  - valid at cycle 10, q element0 = 16'hFF00;
  - ack → IDLE at next cycle.
- relu_en=1, bias_d elements 16'h8000, 16'h0000, 16'h7FFF → q elements 0, 0, 16'h7FFF. pad_en=0 → ZPAD skipped, valid at cycle 8.
- Stray/early done:
  - dotp_done asserted during IM2C is ignored;
  - im2c_done on the same cycle as im2c_go is ignored, so IM2C lasts until a later done.
- Timeout with TIMEOUT=8, dotp_done never asserted → err high exactly 8 cycles after entering DOTP (busy low, valid low, q unchanged); ack → IDLE.
- Start in FINI with layer=5 → layer_o=5, valid drops, zpad_go next cycle. start while busy → ignored, layer_o unchanged.
- Reset asserted during DOTP → all outputs 0 immediately. Released, then start → clean run as in the nominal scenario.
